// File: rtl/sync_decoder.sv
// sync_decoder: recovers pixel coordinates from raw hsync/vsync/de and checks
// the incoming timing against the expected active resolution.
module sync_decoder #(
  parameter int   CORDW       = 10,
  parameter int   H_RES       = 640,
  parameter int   V_RES       = 480,
  parameter logic H_POL       = 1'b0,
  parameter logic V_POL       = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             de,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             de_out,
  output logic             frame,
  output logic             locked,
  output logic             timing_err,
  output logic [CORDW-1:0] width_meas,
  output logic [CORDW-1:0] height_meas
);

  localparam logic [CORDW-1:0] C_ONE   = {{(CORDW-1){1'b0}}, 1'b1};
  localparam logic [CORDW-1:0] C_MAX   = {CORDW{1'b1}};
  localparam logic [CORDW:0]   C_H_RES = (CORDW+1)'(H_RES);
  localparam logic [CORDW:0]   C_V_RES = (CORDW+1)'(V_RES);
  localparam logic [3:0]       C_LOCK  = 4'(LOCK_FRAMES);

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_hs_q, r_vs_q, r_de_q;
  logic             r_vs_p, r_de_p;
  logic [CORDW-1:0] r_sx, r_sy, r_lines, r_width, r_height;
  logic             r_armed, r_seen_vs, r_bad;
  logic             r_de_out, r_frame, r_err;
  logic [3:0]       r_good;
  logic [3:0]       w_good_nxt;
  logic [CORDW-1:0] w_width_sat;
  logic             w_de_rise, w_de_fall, w_vs_edge;
  logic             w_width_bad, w_sanity_bad, w_height_bad, w_mismatch;
  logic             w_frame_good, w_locked;

  function automatic logic [CORDW-1:0] f_sat_inc(input logic [CORDW-1:0] v);
    return (v == C_MAX) ? v : v + C_ONE;
  endfunction

  assign w_de_rise    = r_de_q & ~r_de_p;
  assign w_de_fall    = ~r_de_q & r_de_p;
  assign w_vs_edge    = (r_vs_q == V_POL) & (r_vs_p != V_POL);
  assign w_width_sat  = f_sat_inc(r_sx);
  // Compare one bit wider so a saturated counter can never alias the target.
  assign w_width_bad  = w_de_fall & ({1'b0, w_width_sat} != C_H_RES);
  assign w_sanity_bad = r_de_q & (r_hs_q == H_POL);
  assign w_height_bad = w_vs_edge & r_seen_vs & ({1'b0, r_lines} != C_V_RES);
  assign w_mismatch   = w_width_bad | w_sanity_bad | w_height_bad;
  assign w_frame_good = w_vs_edge & r_seen_vs & ~r_bad & ~w_mismatch;

  // Input registers and their one-cycle history for edge detection.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_hs_q   <= 1'b0;
      r_vs_q   <= 1'b0;
      r_de_q   <= 1'b0;
      r_vs_p   <= 1'b0;
      r_de_p   <= 1'b0;
      r_de_out <= 1'b0;
    end else begin
      r_hs_q   <= hsync;
      r_vs_q   <= vsync;
      r_de_q   <= de;
      r_vs_p   <= r_vs_q;
      r_de_p   <= r_de_q;
      r_de_out <= r_de_q;
    end
  end

  // Coordinate recovery; a vs_edge in the same cycle as de_rise starts line 0.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_sx    <= '0;
      r_sy    <= '0;
      r_lines <= '0;
      r_armed <= 1'b0;
    end else begin
      r_sx <= w_de_rise ? '0 : f_sat_inc(r_sx);
      if (w_vs_edge) begin
        r_armed <= 1'b1;
        r_lines <= '0;
      end
      if (w_de_rise) begin
        if (r_armed || w_vs_edge) begin
          r_sy    <= '0;
          r_armed <= 1'b0;
          r_lines <= C_ONE;
        end else begin
          r_sy    <= f_sat_inc(r_sy);
          r_lines <= f_sat_inc(r_lines);
        end
      end
    end
  end

  // Width/height measurement, strobes and good-frame bookkeeping.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_width   <= '0;
      r_height  <= '0;
      r_frame   <= 1'b0;
      r_err     <= 1'b0;
      r_seen_vs <= 1'b0;
      r_bad     <= 1'b0;
      r_good    <= 4'd0;
    end else begin
      r_frame <= w_de_fall & ({1'b0, r_lines} == C_V_RES);
      r_err   <= w_mismatch;
      r_good  <= w_good_nxt;
      if (w_de_fall) begin
        r_width <= w_width_sat;
      end
      if (w_vs_edge && r_seen_vs) begin
        r_height <= r_lines;
      end
      if (w_vs_edge) begin
        r_seen_vs <= 1'b1;
        r_bad     <= 1'b0;
      end else if (w_mismatch) begin
        r_bad <= 1'b1;
      end
    end
  end

  // Good-frame counter: cleared by any mismatch, saturates at the lock target.
  always_comb begin
    w_good_nxt = r_good;
    if (w_mismatch) begin
      w_good_nxt = 4'd0;
    end else if (w_frame_good && (r_good != C_LOCK)) begin
      w_good_nxt = r_good + 4'd1;
    end else begin
      w_good_nxt = r_good;
    end
  end

  // Lock state register.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_state <= ST_UNLOCKED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Lock next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_good_nxt == C_LOCK) begin
          w_state_nxt = ST_LOCKED;
        end else begin
          w_state_nxt = ST_UNLOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_mismatch) begin
          w_state_nxt = ST_UNLOCKED;
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: w_state_nxt = ST_UNLOCKED;
    endcase
  end

  // Lock output decode.
  always_comb begin
    w_locked = 1'b0;
    case (r_state)
      ST_LOCKED:   w_locked = 1'b1;
      ST_UNLOCKED: w_locked = 1'b0;
      default:     w_locked = 1'b0;
    endcase
  end

  assign sx          = r_sx;
  assign sy          = r_sy;
  assign de_out      = r_de_out;
  assign frame       = r_frame;
  assign locked      = w_locked;
  assign timing_err  = r_err;
  assign width_meas  = r_width;
  assign height_meas = r_height;

endmodule

// File: tb/tb_sync_decoder.sv
// Randomised-porch video stream checked cycle by cycle against a behavioural
// model of the sync decoder, plus scenario checks for the lock/error rules.
module tb_sync_decoder;

  localparam int CORDW = 10;
  localparam int H_RES = 16;
  localparam int V_RES = 6;
  localparam int LOCK  = 2;
  localparam int MAXC  = 1023;

  logic clk_pix   = 1'b0;
  logic rst_pix_n = 1'b0;
  logic hsync     = 1'b1;
  logic vsync     = 1'b1;
  logic de        = 1'b0;
  logic [CORDW-1:0] sx, sy, width_meas, height_meas;
  logic de_out, frame, locked, timing_err;

  sync_decoder #(
    .CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES),
    .H_POL(1'b0), .V_POL(1'b0), .LOCK_FRAMES(LOCK)
  ) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .hsync(hsync), .vsync(vsync), .de(de),
    .sx(sx), .sy(sy), .de_out(de_out), .frame(frame), .locked(locked),
    .timing_err(timing_err), .width_meas(width_meas), .height_meas(height_meas)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct packed { logic h; logic v; logic d; } samp_t;
  samp_t stim[$];
  samp_t pipe[$];
  int checks = 0;
  int errors = 0;

  int m_sx, m_sy, m_lines, m_wm, m_hm, m_good;
  bit m_armed, m_seen, m_bad, m_frame, m_err, m_deo;

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  function automatic logic [43:0] act_vec();
    return {sx, sy, de_out, frame, locked, timing_err, width_meas, height_meas};
  endfunction

  function automatic logic [43:0] exp_vec();
    logic lk;
    lk = (m_good >= LOCK);
    return {10'(m_sx), 10'(m_sy), m_deo, m_frame, lk, m_err, 10'(m_wm), 10'(m_hm)};
  endfunction

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_lines = 0; m_wm = 0; m_hm = 0; m_good = 0;
    m_armed = 0; m_seen = 0; m_bad = 0; m_frame = 0; m_err = 0; m_deo = 0;
    pipe.delete();
    pipe.push_back(3'b000);
    pipe.push_back(3'b000);
  endtask

  // Effect of one clock edge; pipe holds the previous and current registered samples.
  task automatic model_edge(input samp_t s);
    samp_t prv, cur;
    bit rise, fall, vse, mm;
    prv  = pipe[0];
    cur  = pipe[1];
    rise = cur.d && !prv.d;
    fall = !cur.d && prv.d;
    vse  = !cur.v && prv.v;
    mm   = cur.d && !cur.h;
    m_deo   = cur.d;
    m_frame = fall && (m_lines == V_RES);
    if (fall) begin
      m_wm = sat(m_sx + 1);
      if (m_wm != H_RES) mm = 1;
    end
    if (vse && m_seen) begin
      m_hm = m_lines;
      if (m_lines != V_RES) mm = 1;
    end
    m_sx = rise ? 0 : sat(m_sx + 1);
    if (vse) begin
      m_armed = 1; m_lines = 0;
    end
    if (rise) begin
      if (m_armed) begin
        m_sy = 0; m_armed = 0; m_lines = 1;
      end else begin
        m_sy = sat(m_sy + 1); m_lines = sat(m_lines + 1);
      end
    end
    if (mm) m_good = 0;
    else if (vse && m_seen && !m_bad) m_good = (m_good < LOCK) ? m_good + 1 : LOCK;
    if (vse) begin
      m_bad = 0; m_seen = 1;
    end else if (mm) begin
      m_bad = 1;
    end
    m_err = mm;
    void'(pipe.pop_front());
    pipe.push_back(s);
  endtask

  task automatic step(input samp_t s);
    hsync = s.h; vsync = s.v; de = s.d;
    @(posedge clk_pix);
    model_edge(s);
    @(negedge clk_pix);
  endtask

  task automatic gen_line(input int act, input logic v_pre, input logic v_act);
    int bp, fp;
    bp = $urandom_range(4, 2);
    fp = $urandom_range(3, 1);
    repeat (bp)  stim.push_back('{1'b1, v_pre, 1'b0});
    repeat (act) stim.push_back('{1'b1, v_act, 1'b1});
    repeat (fp)  stim.push_back('{1'b1, v_act, 1'b0});
    repeat (3)   stim.push_back('{1'b0, v_act, 1'b0});
  endtask

  task automatic gen_frame(input int nlines, input int short_idx);
    repeat (2) gen_line(0, 1'b0, 1'b0);
    repeat ($urandom_range(2, 1)) gen_line(0, 1'b1, 1'b1);
    for (int i = 0; i < nlines; i++) gen_line((i == short_idx) ? H_RES - 1 : H_RES, 1'b1, 1'b1);
    repeat ($urandom_range(2, 1)) gen_line(0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    rst_pix_n = 1'b0; hsync = 1'b1; vsync = 1'b1; de = 1'b1;
    repeat (3) @(negedge clk_pix);
    checks++;
    if (act_vec() !== 44'd0) begin
      errors++; $display("FAIL reset_outputs act=%h exp=0", act_vec());
    end
    de = 1'b0;
    rst_pix_n = 1'b1;
    model_reset();
  endtask

  task automatic test_lock();
    int nv, rise_at, errs, frames;
    logic pv, pl;
    samp_t s;
    nv = 0; rise_at = -1; errs = 0; frames = 0; pv = 1'b1; pl = locked;
    repeat (2) gen_line(0, 1'b1, 1'b1);
    repeat (4) gen_frame(V_RES, -1);
    while (stim.size() > 0) begin
      s = stim.pop_front();
      if (pv && !s.v) nv++;
      pv = s.v;
      step(s);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL lock_cycle act=%h exp=%h", act_vec(), exp_vec());
      end
      if (locked && !pl && rise_at < 0) rise_at = nv;
      pl = locked; errs += int'(timing_err); frames += int'(frame);
    end
    checks++;
    if (rise_at != 3) begin errors++; $display("FAIL lock_rise_edge act=%0d exp=3", rise_at); end
    checks++;
    if (errs != 0) begin errors++; $display("FAIL lock_no_err act=%0d exp=0", errs); end
    checks++;
    if (frames != 4) begin errors++; $display("FAIL lock_frames act=%0d exp=4", frames); end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL lock_final act=%b exp=1", locked); end
  endtask

  task automatic test_short_line();
    int nv, relock_at;
    bit saw;
    logic pv, pl;
    samp_t s;
    nv = 0; relock_at = -1; saw = 0; pv = 1'b1; pl = locked;
    gen_frame(V_RES, 2);
    repeat (3) gen_frame(V_RES, -1);
    while (stim.size() > 0) begin
      s = stim.pop_front();
      if (pv && !s.v) nv++;
      pv = s.v;
      step(s);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL short_cycle act=%h exp=%h", act_vec(), exp_vec());
      end
      if (!saw && timing_err && width_meas == 10'(H_RES - 1) && !locked) begin
        saw = 1; nv = 0;
      end
      if (saw && locked && !pl && relock_at < 0) relock_at = nv;
      pl = locked;
    end
    checks++;
    if (!saw) begin errors++; $display("FAIL short_err_seen act=0 exp=1"); end
    checks++;
    if (relock_at != 3) begin errors++; $display("FAIL short_relock_edge act=%0d exp=3", relock_at); end
  endtask

  task automatic test_drop_line();
    int frames;
    bit saw;
    samp_t s;
    frames = 0; saw = 0;
    gen_frame(V_RES - 1, -1);
    while (stim.size() > 0) begin
      s = stim.pop_front();
      step(s);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL drop_cycle act=%h exp=%h", act_vec(), exp_vec());
      end
      frames += int'(frame);
    end
    gen_frame(V_RES, -1);
    while (stim.size() > 0) begin
      s = stim.pop_front();
      step(s);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL drop_cycle2 act=%h exp=%h", act_vec(), exp_vec());
      end
      if (timing_err && height_meas == 10'(V_RES - 1) && !locked) saw = 1;
    end
    checks++;
    if (frames != 0) begin errors++; $display("FAIL drop_no_frame act=%0d exp=0", frames); end
    checks++;
    if (!saw) begin errors++; $display("FAIL drop_height_err act=0 exp=1"); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL drop_unlocked act=%b exp=0", locked); end
  endtask

  task automatic test_saturate();
    int maxsx;
    bit saw;
    samp_t s;
    maxsx = 0; saw = 0;
    gen_line(0, 1'b1, 1'b1);
    repeat (1100) stim.push_back('{1'b1, 1'b1, 1'b1});
    gen_line(0, 1'b1, 1'b1);
    while (stim.size() > 0) begin
      s = stim.pop_front();
      step(s);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL sat_cycle act=%h exp=%h", act_vec(), exp_vec());
      end
      if (de_out && int'(sx) > maxsx) maxsx = int'(sx);
      if (timing_err && width_meas == 10'(MAXC)) saw = 1;
    end
    checks++;
    if (maxsx != MAXC) begin errors++; $display("FAIL sat_sx act=%0d exp=%0d", maxsx, MAXC); end
    checks++;
    if (!saw) begin errors++; $display("FAIL sat_width_err act=0 exp=1"); end
  endtask

  task automatic test_reset_midline();
    int nv, rise_at, k;
    bit hit;
    logic pv, pl;
    samp_t s;
    hit = 0;
    repeat (2) gen_line(0, 1'b1, 1'b1);
    repeat (400) stim.push_back('{1'b1, 1'b1, 1'b1});
    while (stim.size() > 0) begin
      s = stim.pop_front();
      step(s);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL mid_pre_cycle act=%h exp=%h", act_vec(), exp_vec());
      end
      if (de_out && sx == 10'd300) begin
        hit = 1; stim.delete();
      end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL mid_reach_300 act=0 exp=1"); end
    #2 rst_pix_n = 1'b0;
    #1;
    checks++;
    if (act_vec() !== 44'd0) begin errors++; $display("FAIL mid_async_reset act=%h exp=0", act_vec()); end
    @(negedge clk_pix);
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    model_reset();
    repeat (50) stim.push_back('{1'b1, 1'b1, 1'b1});
    repeat (2) gen_line(0, 1'b1, 1'b1);
    repeat (4) gen_frame(V_RES, -1);
    nv = 0; rise_at = -1; k = 0; pv = 1'b1; pl = 1'b0;
    while (stim.size() > 0) begin
      s = stim.pop_front();
      if (pv && !s.v) nv++;
      pv = s.v;
      step(s);
      k++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL mid_post_cycle act=%h exp=%h", act_vec(), exp_vec());
      end
      if (k == 2) begin
        checks++;
        if (sy !== 10'd1) begin errors++; $display("FAIL mid_sy_unarmed act=%0d exp=1", sy); end
      end
      if (locked && !pl && rise_at < 0) rise_at = nv;
      pl = locked;
    end
    checks++;
    if (rise_at != 3) begin errors++; $display("FAIL mid_relock_edge act=%0d exp=3", rise_at); end
  endtask

  task automatic test_simultaneous();
    int errs, frames;
    bit first;
    logic [CORDW-1:0] f_sy, f_hm;
    logic f_err;
    samp_t s;
    errs = 0; frames = 0; first = 1; f_sy = '1; f_hm = '0; f_err = 1'b1;
    gen_line(H_RES, 1'b1, 1'b0);
    for (int i = 1; i < V_RES; i++) gen_line(H_RES, 1'b1, 1'b1);
    gen_line(0, 1'b1, 1'b1);
    gen_frame(V_RES, -1);
    while (stim.size() > 0) begin
      s = stim.pop_front();
      step(s);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL simul_cycle act=%h exp=%h", act_vec(), exp_vec());
      end
      if (first && de_out) begin
        first = 0; f_sy = sy; f_hm = height_meas; f_err = timing_err;
      end
      errs += int'(timing_err); frames += int'(frame);
    end
    checks++;
    if (f_sy !== 10'd0 || f_err !== 1'b0 || f_hm !== 10'(V_RES)) begin
      errors++; $display("FAIL simul_first_line act=sy%0d/err%b/h%0d exp=sy0/err0/h%0d", f_sy, f_err, f_hm, V_RES);
    end
    checks++;
    if (errs != 0 || height_meas !== 10'(V_RES) || frames != 2) begin
      errors++; $display("FAIL simul_next_frame act=err%0d/h%0d/f%0d exp=err0/h%0d/f2", errs, height_meas, frames, V_RES);
    end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL simul_locked act=%b exp=1", locked); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock();
    test_short_line();
    test_drop_line();
    test_saturate();
    test_reset_midline();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
